// File: rtl/mem_access_unit_mc.sv
// rtl/mem_access_unit_mc.sv - multicycle memory access sequencer for a request/grant bus
//
// Takes one fetch/load/store per instruction from the control FSM, drives the
// external bus with byte-enables and lane-replicated write data, waits for the
// response (with a timeout) and returns formatted load data.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   req_i                  access request, held by the control FSM until done_o
//   fetch_i, we_i          fetch (word read) / store select
//   funct3_i               RV32I load/store size code
//   adr_i, wdata_i         byte address, right-aligned store data
//   done_o                 one-cycle completion pulse
//   rdata_o                formatted read data, held until the next completed read
//   misaligned_o, err_o    completion qualifiers, valid only with done_o
//   bus_req_o .. bus_wdata_o   request side of the memory bus
//   bus_gnt_i .. bus_err_i     grant and response side of the memory bus

module mem_access_unit_mc #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        fetch_i,
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] wdata_i,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o,
    output logic        err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_adr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Last count value allowed in REQ/WAIT before the access is abandoned.
    localparam logic [9:0] CNT_LAST = 10'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [9:0]  cnt;

    // Format info captured at request time, used when the read data returns.
    logic [2:0]  fmt_f3;
    logic        fmt_fetch;
    logic [1:0]  fmt_off;

    // Request decode (IDLE only).
    logic [1:0]  size;
    logic        illegal;
    logic        misaligned;
    logic [3:0]  be_dec;
    logic [31:0] wdata_dec;

    always_comb begin
        size    = fetch_i ? 2'd2 : funct3_i[1:0];
        illegal = 1'b0;
        if (!fetch_i) begin
            if (we_i) begin
                illegal = !(funct3_i inside {3'b000, 3'b001, 3'b010});
            end else begin
                illegal = !(funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
            end
        end

        misaligned = 1'b0;
        be_dec     = 4'b1111;
        wdata_dec  = wdata_i;
        case (size)
            2'd0: begin
                be_dec    = 4'b0001 << adr_i[1:0];
                wdata_dec = {4{wdata_i[7:0]}};
            end
            2'd1: begin
                misaligned = adr_i[0];
                be_dec     = adr_i[1] ? 4'b1100 : 4'b0011;
                wdata_dec  = {2{wdata_i[15:0]}};
            end
            default: begin
                misaligned = (adr_i[1:0] != 2'b00);
            end
        endcase
    end

    // Load data formatting from the captured lane offset and size code.
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_fmt;

    always_comb begin
        case (fmt_off)
            2'd0:    rd_byte = bus_rdata_i[7:0];
            2'd1:    rd_byte = bus_rdata_i[15:8];
            2'd2:    rd_byte = bus_rdata_i[23:16];
            default: rd_byte = bus_rdata_i[31:24];
        endcase
        rd_half = fmt_off[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];

        rd_fmt = bus_rdata_i;
        if (!fmt_fetch) begin
            case (fmt_f3)
                3'b000:  rd_fmt = {{24{rd_byte[7]}}, rd_byte};
                3'b100:  rd_fmt = {24'd0, rd_byte};
                3'b001:  rd_fmt = {{16{rd_half[15]}}, rd_half};
                3'b101:  rd_fmt = {16'd0, rd_half};
                default: rd_fmt = bus_rdata_i;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            fmt_f3       <= '0;
            fmt_fetch    <= 1'b0;
            fmt_off      <= '0;
            done_o       <= 1'b0;
            misaligned_o <= 1'b0;
            err_o        <= 1'b0;
            rdata_o      <= '0;
            bus_req_o    <= 1'b0;
            bus_we_o     <= 1'b0;
            bus_adr_o    <= '0;
            bus_be_o     <= '0;
            bus_wdata_o  <= '0;
        end else begin
            // Completion flags are single-cycle; only the DONE entry sets them.
            done_o       <= 1'b0;
            misaligned_o <= 1'b0;
            err_o        <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (req_i) begin
                        if (illegal) begin
                            done_o <= 1'b1;
                            err_o  <= 1'b1;
                            state  <= ST_DONE;
                        end else if (misaligned) begin
                            done_o       <= 1'b1;
                            misaligned_o <= 1'b1;
                            state        <= ST_DONE;
                        end else begin
                            bus_req_o   <= 1'b1;
                            bus_we_o    <= we_i & ~fetch_i;
                            bus_adr_o   <= {adr_i[31:2], 2'b00};
                            bus_be_o    <= be_dec;
                            bus_wdata_o <= wdata_dec;
                            fmt_f3      <= funct3_i;
                            fmt_fetch   <= fetch_i;
                            fmt_off     <= adr_i[1:0];
                            cnt         <= '0;
                            state       <= ST_REQ;
                        end
                    end
                end

                ST_REQ: begin
                    // Timeout wins over a same-cycle grant: the access is dropped.
                    if (cnt == CNT_LAST) begin
                        bus_req_o <= 1'b0;
                        done_o    <= 1'b1;
                        err_o     <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        cnt <= cnt + 10'd1;
                        if (bus_gnt_i) begin
                            bus_req_o <= 1'b0;
                            state     <= ST_WAIT;
                        end
                    end
                end

                ST_WAIT: begin
                    if (bus_rvalid_i) begin
                        done_o <= 1'b1;
                        err_o  <= bus_err_i;
                        state  <= ST_DONE;
                        if (!bus_err_i && !bus_we_o) begin
                            rdata_o <= rd_fmt;
                        end
                    end else if (cnt == CNT_LAST) begin
                        done_o <= 1'b1;
                        err_o  <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
